// File: rtl/axi_dmem_responder_if.sv
// AXI4-Lite bus bundle between a requesting master and the data-memory responder.
// Carries the AW, W, B, AR and R channels; clock and reset stay outside the bundle.
//   master : drives addresses, write data/strobes, VALIDs on AW/W/AR, BREADY, RREADY
//   slave  : drives AWREADY, WREADY, ARREADY, BRESP/BVALID, RDATA/RRESP/RVALID
interface axi_dmem_responder_if;
    logic [31:0] AWADDR;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [31:0] ARADDR;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY;

    modport master (
        output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport slave (
        input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
endinterface

// File: rtl/axi_dmem_responder.sv
// AXI4-Lite data-memory responder with a single outstanding transaction.
// Holds 2^(ADDR_W-2) 32-bit words; addresses with bits above ADDR_W set get SLVERR.
// Ports:
//   CLK  : sole clock, rising edge
//   RST  : synchronous active-high reset
//   bus  : AXI4-Lite slave modport (AW/W/B/AR/R channels)
// Parameters:
//   ADDR_W      : decoded byte-address width
//   WAIT_CYCLES : extra cycles (0..15) inserted before BVALID/RVALID
module axi_dmem_responder #(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic                 CLK,
    input  logic                 RST,
    axi_dmem_responder_if.slave  bus
);

    localparam int unsigned IDX_W = ADDR_W - 2;
    localparam int unsigned DEPTH = 1 << IDX_W;
    localparam int unsigned CNT_W = 4;

    localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);
    localparam logic [1:0]       OKAY    = 2'b00;
    localparam logic [1:0]       SLVERR  = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WR_COLLECT,
        WR_WAIT,
        WR_RESP,
        RD_WAIT,
        RD_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              have_aw_q, have_aw_d;
    logic              have_w_q, have_w_d;
    logic [31:0]       aw_addr_q, aw_addr_d;
    logic [31:0]       w_data_q, w_data_d;
    logic [3:0]        w_strb_q, w_strb_d;
    logic [31:0]       ar_addr_q, ar_addr_d;

    logic              awready_q, awready_d;
    logic              wready_q, wready_d;
    logic              arready_q, arready_d;
    logic              bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic              rvalid_q, rvalid_d;
    logic [1:0]        rresp_q, rresp_d;
    logic [31:0]       rdata_q, rdata_d;

    logic              wr_fire_c;
    logic [31:0]       wr_addr_c;
    logic [31:0]       wr_data_c;
    logic [3:0]        wr_strb_c;
    logic [IDX_W-1:0]  wr_idx_c;
    logic              rd_sample_c;
    logic [31:0]       rd_addr_c;
    logic [IDX_W-1:0]  rd_idx_c;

    logic [31:0]       mem [DEPTH];

    // Address decodes when no bit above the decoded window is set.
    function automatic logic in_range(input logic [31:0] a);
        return (a >> ADDR_W) == 32'd0;
    endfunction

    // Next-state, transaction bookkeeping and next values of the registered outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        have_aw_d   = have_aw_q;
        have_w_d    = have_w_q;
        aw_addr_d   = aw_addr_q;
        w_data_d    = w_data_q;
        w_strb_d    = w_strb_q;
        ar_addr_d   = ar_addr_q;
        bresp_d     = bresp_q;
        rresp_d     = rresp_q;
        rdata_d     = rdata_q;
        wr_fire_c   = 1'b0;
        rd_sample_c = 1'b0;
        // A channel already latched supplies its value; the other comes straight off the bus.
        wr_addr_c   = have_aw_q ? aw_addr_q : bus.AWADDR;
        wr_data_c   = have_w_q  ? w_data_q  : bus.WDATA;
        wr_strb_c   = have_w_q  ? w_strb_q  : bus.WSTRB;
        wr_idx_c    = wr_addr_c[ADDR_W-1:2];
        rd_addr_c   = (state_q == IDLE) ? bus.ARADDR : ar_addr_q;
        rd_idx_c    = rd_addr_c[ADDR_W-1:2];

        case (state_q)
            IDLE: begin
                // Any write activity takes priority; the read waits until we return here.
                if (bus.AWVALID || bus.WVALID) begin
                    if (bus.AWVALID) begin
                        have_aw_d = 1'b1;
                        aw_addr_d = bus.AWADDR;
                    end
                    if (bus.WVALID) begin
                        have_w_d = 1'b1;
                        w_data_d = bus.WDATA;
                        w_strb_d = bus.WSTRB;
                    end
                    if (bus.AWVALID && bus.WVALID) begin
                        wr_fire_c = 1'b1;
                    end else begin
                        state_d = WR_COLLECT;
                    end
                end else if (bus.ARVALID) begin
                    ar_addr_d = bus.ARADDR;
                    if (WAIT_CYCLES == 0) begin
                        state_d     = RD_RESP;
                        rd_sample_c = 1'b1;
                    end else begin
                        state_d = RD_WAIT;
                        cnt_d   = WAIT_LD;
                    end
                end
            end
            WR_COLLECT: begin
                if ((!have_aw_q && bus.AWVALID) || (!have_w_q && bus.WVALID)) begin
                    wr_fire_c = 1'b1;
                end
            end
            WR_WAIT: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = WR_RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WR_RESP: begin
                if (bus.BREADY) begin
                    state_d = IDLE;
                end
            end
            RD_WAIT: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d     = RD_RESP;
                    cnt_d       = '0;
                    rd_sample_c = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RD_RESP: begin
                if (bus.RREADY) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Second half of the write arrived: memory updates on this edge, response follows.
        if (wr_fire_c) begin
            have_aw_d = 1'b0;
            have_w_d  = 1'b0;
            bresp_d   = in_range(wr_addr_c) ? OKAY : SLVERR;
            if (WAIT_CYCLES == 0) begin
                state_d = WR_RESP;
            end else begin
                state_d = WR_WAIT;
                cnt_d   = WAIT_LD;
            end
        end

        // Read data is captured once, on the way into RD_RESP, so it stays stable there.
        if (rd_sample_c) begin
            rdata_d = in_range(rd_addr_c) ? mem[rd_idx_c] : 32'd0;
            rresp_d = in_range(rd_addr_c) ? OKAY : SLVERR;
        end

        awready_d = (state_d == IDLE) || ((state_d == WR_COLLECT) && !have_aw_d);
        wready_d  = (state_d == IDLE) || ((state_d == WR_COLLECT) && !have_w_d);
        arready_d = (state_d == IDLE);
        bvalid_d  = (state_d == WR_RESP);
        rvalid_d  = (state_d == RD_RESP);
    end

    // State and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            have_aw_q <= 1'b0;
            have_w_q  <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            ar_addr_q <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            arready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
            rvalid_q  <= 1'b0;
            rresp_q   <= OKAY;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            have_aw_q <= have_aw_d;
            have_w_q  <= have_w_d;
            aw_addr_q <= aw_addr_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            ar_addr_q <= ar_addr_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            arready_q <= arready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end

    // Storage survives reset; only a completed, in-range write touches it.
    always_ff @(posedge CLK) begin
        if (!RST && wr_fire_c && in_range(wr_addr_c)) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_strb_c[i]) begin
                    mem[wr_idx_c][8*i +: 8] <= wr_data_c[8*i +: 8];
                end
            end
        end
    end

    assign bus.AWREADY = awready_q;
    assign bus.WREADY  = wready_q;
    assign bus.ARREADY = arready_q;
    assign bus.BVALID  = bvalid_q;
    assign bus.BRESP   = bresp_q;
    assign bus.RVALID  = rvalid_q;
    assign bus.RRESP   = rresp_q;
    assign bus.RDATA   = rdata_q;

endmodule

// File: tb/tb_axi_dmem_responder.sv
// Testbench for axi_dmem_responder: one instance with no wait cycles, one with three.
// Stimulus is shared and steered to the selected instance; a word/byte-level memory
// model in the bench supplies every expected read value and response code.
module tb_axi_dmem_responder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi_dmem_responder_if bus0();
    axi_dmem_responder_if bus3();

    axi_dmem_responder #(.ADDR_W(12), .WAIT_CYCLES(0)) u_dut0 (.CLK(clk), .RST(rst), .bus(bus0));
    axi_dmem_responder #(.ADDR_W(12), .WAIT_CYCLES(3)) u_dut3 (.CLK(clk), .RST(rst), .bus(bus3));

    int          sel;
    logic [31:0] awaddr, wdata, araddr;
    logic [3:0]  wstrb;
    logic        awvalid, wvalid, arvalid, bready, rready;

    assign bus0.AWADDR  = awaddr;  assign bus3.AWADDR  = awaddr;
    assign bus0.WDATA   = wdata;   assign bus3.WDATA   = wdata;
    assign bus0.WSTRB   = wstrb;   assign bus3.WSTRB   = wstrb;
    assign bus0.ARADDR  = araddr;  assign bus3.ARADDR  = araddr;
    assign bus0.AWVALID = awvalid && (sel == 0);  assign bus3.AWVALID = awvalid && (sel == 1);
    assign bus0.WVALID  = wvalid  && (sel == 0);  assign bus3.WVALID  = wvalid  && (sel == 1);
    assign bus0.ARVALID = arvalid && (sel == 0);  assign bus3.ARVALID = arvalid && (sel == 1);
    assign bus0.BREADY  = bready  && (sel == 0);  assign bus3.BREADY  = bready  && (sel == 1);
    assign bus0.RREADY  = rready  && (sel == 0);  assign bus3.RREADY  = rready  && (sel == 1);

    logic        awready, wready, arready, bvalid, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    assign awready = (sel == 1) ? bus3.AWREADY : bus0.AWREADY;
    assign wready  = (sel == 1) ? bus3.WREADY  : bus0.WREADY;
    assign arready = (sel == 1) ? bus3.ARREADY : bus0.ARREADY;
    assign bvalid  = (sel == 1) ? bus3.BVALID  : bus0.BVALID;
    assign bresp   = (sel == 1) ? bus3.BRESP   : bus0.BRESP;
    assign rvalid  = (sel == 1) ? bus3.RVALID  : bus0.RVALID;
    assign rresp   = (sel == 1) ? bus3.RRESP   : bus0.RRESP;
    assign rdata   = (sel == 1) ? bus3.RDATA   : bus0.RDATA;

    // Reference memory: contents plus which bytes have ever been written, per instance.
    logic [31:0] mmem  [2][1024];
    logic [3:0]  known [2][1024];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int waitc();
        return (sel == 1) ? 3 : 0;
    endfunction

    function automatic logic in_rng(input logic [31:0] a);
        return a < 32'h1000;
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'(a % 32'h1000) / 4;
    endfunction

    function automatic logic [31:0] exp_resp(input logic [31:0] a);
        return in_rng(a) ? 32'd0 : 32'd2;
    endfunction

    task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int i;
        if (in_rng(addr)) begin
            i = widx(addr);
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) mmem[sel][i][8*b +: 8] = data[8*b +: 8];
            end
            known[sel][i] = known[sel][i] | strb;
        end
    endtask

    // order 0: AW and W together; 1: W first; 2: AW first. gap = cycles between the two.
    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                      input int order, input int gap);
        int n;
        bready = 1'b1;
        if (order == 0) begin
            awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
            chk("aw_ready_idle", 32'(awready), 32'd1);
            chk("w_ready_idle", 32'(wready), 32'd1);
            tick();
            awvalid = 1'b0; wvalid = 1'b0;
        end else begin
            if (order == 1) begin
                wdata = data; wstrb = strb; wvalid = 1'b1;
                chk("w_ready_idle", 32'(wready), 32'd1);
                tick();
                wvalid = 1'b0;
                chk("w_not_reaccepted", 32'(wready), 32'd0);
                chk("aw_still_open", 32'(awready), 32'd1);
            end else begin
                awaddr = addr; awvalid = 1'b1;
                chk("aw_ready_idle", 32'(awready), 32'd1);
                tick();
                awvalid = 1'b0;
                chk("aw_not_reaccepted", 32'(awready), 32'd0);
                chk("w_still_open", 32'(wready), 32'd1);
            end
            chk("b_low_collect", 32'(bvalid), 32'd0);
            chk("ar_low_collect", 32'(arready), 32'd0);
            repeat (gap - 1) tick();
            if (order == 1) begin
                awaddr = addr; awvalid = 1'b1;
                chk("aw_ready_collect", 32'(awready), 32'd1);
                tick();
                awvalid = 1'b0;
            end else begin
                wdata = data; wstrb = strb; wvalid = 1'b1;
                chk("w_ready_collect", 32'(wready), 32'd1);
                tick();
                wvalid = 1'b0;
            end
        end
        model_write(addr, data, strb);
        n = 0;
        while (bvalid !== 1'b1 && n < 40) begin tick(); n++; end
        chk("b_latency", 32'(n), 32'(waitc()));
        chk("bresp", 32'(bresp), exp_resp(addr));
        tick();
        chk("b_dropped", 32'(bvalid), 32'd0);
        bready = 1'b0;
    endtask

    // rdelay < 0: RREADY high before the request; otherwise RVALID is held that many cycles.
    task automatic rd(input logic [31:0] addr, input int rdelay);
        logic [31:0] exp_d;
        int n;
        exp_d  = in_rng(addr) ? mmem[sel][widx(addr)] : 32'd0;
        rready = (rdelay < 0);
        araddr = addr; arvalid = 1'b1;
        n = 0;
        while (arready !== 1'b1 && n < 40) begin tick(); n++; end
        chk("ar_accept", 32'(arready), 32'd1);
        tick();
        arvalid = 1'b0;
        n = 0;
        while (rvalid !== 1'b1 && n < 40) begin tick(); n++; end
        chk("r_latency", 32'(n), 32'(waitc()));
        chk("rdata", rdata, exp_d);
        chk("rresp", 32'(rresp), exp_resp(addr));
        for (int i = 0; i < rdelay; i++) begin
            tick();
            chk("rvalid_hold", 32'(rvalid), 32'd1);
            chk("rdata_hold", rdata, exp_d);
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        chk("r_dropped", 32'(rvalid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, d;
        int          idx, tries;
        logic        done;

        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 1024; i++) known[s][i] = 4'h0;
        sel = 0;
        rst = 1'b1;
        awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b0; rready = 1'b0;
        repeat (3) tick();

        // Reset values on both instances.
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #0;
            chk("rst_awready", 32'(awready), 32'd0);
            chk("rst_wready", 32'(wready), 32'd0);
            chk("rst_arready", 32'(arready), 32'd0);
            chk("rst_bvalid", 32'(bvalid), 32'd0);
            chk("rst_rvalid", 32'(rvalid), 32'd0);
            chk("rst_bresp", 32'(bresp), 32'd0);
            chk("rst_rresp", 32'(rresp), 32'd0);
            chk("rst_rdata", rdata, 32'd0);
        end
        rst = 1'b0;
        tick();
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #0;
            chk("post_rst_awready", 32'(awready), 32'd1);
            chk("post_rst_arready", 32'(arready), 32'd1);
        end
        sel = 0;

        // Same-cycle write then readback; W-first partial write three cycles ahead of AW.
        wr(32'h10, 32'hDEADBEEF, 4'b1111, 0, 1);
        rd(32'h10, 0);
        wr(32'h10, 32'h000000AA, 4'b0001, 1, 3);
        rd(32'h10, 1);
        chk("merged_word", mmem[0][4], 32'hDEADBEAA);

        // Out-of-range read and write; word 0 must survive the aliasing write.
        wr(32'h0, 32'h11223344, 4'b1111, 2, 2);
        rd(32'h2000, 0);
        wr(32'h2000, 32'h99999999, 4'b1111, 0, 1);
        rd(32'h0, -1);
        wr(32'h14, 32'h5A5A5A5A, 4'b0000, 0, 1);

        // Write and read requested in the same IDLE cycle: write first, read afterwards.
        awaddr = 32'h40; wdata = 32'hCAFEF00D; wstrb = 4'hF; araddr = 32'h40;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1;
        chk("arb_awready", 32'(awready), 32'd1);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        model_write(32'h40, 32'hCAFEF00D, 4'hF);
        chk("arb_ar_blocked", 32'(arready), 32'd0);
        chk("arb_bvalid", 32'(bvalid), 32'd1);
        chk("arb_rvalid", 32'(rvalid), 32'd0);
        tick();
        bready = 1'b0;
        chk("arb_b_done", 32'(bvalid), 32'd0);
        chk("arb_ar_open", 32'(arready), 32'd1);
        tick();
        arvalid = 1'b0;
        chk("arb_rvalid_up", 32'(rvalid), 32'd1);
        chk("arb_rdata", rdata, 32'hCAFEF00D);
        rready = 1'b1;
        tick();
        rready = 1'b0;
        chk("arb_r_done", 32'(rvalid), 32'd0);

        // Reset with only AW collected: abandoned, memory intact, next write normal.
        wr(32'h20, 32'h55AA55AA, 4'hF, 0, 1);
        awaddr = 32'h20; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        chk("collect_wready", 32'(wready), 32'd1);
        wdata = 32'hFFFFFFFF; wstrb = 4'hF;
        rst = 1'b1;
        tick();
        chk("mid_rst_awready", 32'(awready), 32'd0);
        chk("mid_rst_wready", 32'(wready), 32'd0);
        chk("mid_rst_bvalid", 32'(bvalid), 32'd0);
        chk("mid_rst_rvalid", 32'(rvalid), 32'd0);
        rst = 1'b0;
        tick();
        chk("after_rst_wready", 32'(wready), 32'd1);
        rd(32'h20, 0);
        wr(32'h20, 32'h01020304, 4'hF, 2, 1);
        rd(32'h20, 2);

        // Three wait cycles: RVALID four cycles after AR, held while RREADY stays low.
        sel = 1;
        wr(32'h80, 32'h12345678, 4'hF, 0, 1);
        rd(32'h80, 5);
        wr(32'h84, 32'hA5A5A5A5, 4'b0110, 1, 2);
        wr(32'h2004, 32'h0, 4'hF, 2, 1);

        // Randomised traffic on both instances.
        for (int s = 0; s < 2; s++) begin
            sel = s;
            for (int t = 0; t < 30; t++) begin
                if ($urandom_range(0, 1) == 0) begin
                    if ($urandom_range(0, 5) == 0)
                        a = (32'h1000 << $urandom_range(0, 19)) | 32'($urandom_range(0, 4095));
                    else
                        a = 32'($urandom_range(0, 31) * 16) | 32'($urandom_range(0, 3));
                    d = $urandom;
                    wr(a, d, 4'($urandom_range(0, 15)), int'($urandom_range(0, 2)),
                       int'($urandom_range(1, 3)));
                end else begin
                    done  = 1'b0;
                    tries = 0;
                    while (!done && tries < 8) begin
                        idx = int'($urandom_range(0, 31)) * 4;
                        if (known[sel][idx] == 4'hF) begin
                            rd(32'(idx * 4) | 32'($urandom_range(0, 3)),
                               int'($urandom_range(0, 4)) - 1);
                            done = 1'b1;
                        end
                        tries++;
                    end
                    if (!done) rd(32'h4000_0000 | 32'($urandom_range(0, 4095)), 1);
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
